acc_seq: RTL and testbench

- Control sequencer for the 4-bit accumulator/ALU datapath.
- Accepts one opcode per valid/ready handshake from the instruction decoder.
- Drives the datapath strobes in the order each operation needs: s_add/s_sub/s_and/s_mul/s_div, ah_inen, ah_reset, clr, acc_oen, and the hs/ls shift-mode selects.
- Sequences the multi-cycle shift-add multiply and shift-subtract divide with an iteration counter, then reports completion with a one-cycle done pulse.

---
 rtl/acc_seq_pkg.sv | 99 +++++++++
 rtl/acc_seq_if.sv | 11 +
 rtl/acc_seq_cnt.sv | 28 ++
 rtl/acc_seq.sv | 108 ++++++++++
 tb/tb_acc_seq.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_seq_pkg.sv
// Shared opcode/mode constants, FSM state encoding and the state-to-strobe decode
// for the accumulator control sequencer.
package acc_seq_pkg;

  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_CLR = 3'b000;
  localparam logic [OPW-1:0] OP_LDA = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_SUB = 3'b011;
  localparam logic [OPW-1:0] OP_AND = 3'b100;
  localparam logic [OPW-1:0] OP_MUL = 3'b101;
  localparam logic [OPW-1:0] OP_DIV = 3'b110;
  localparam logic [OPW-1:0] OP_OUT = 3'b111;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLRS,
    ST_LOAD,
    ST_EXEC,
    ST_PREP,
    ST_M_ADD,
    ST_M_SHF,
    ST_D_SHF,
    ST_D_SUB,
    ST_OUTP,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       op_ready;
    logic       busy;
    logic       done;
    logic       ah_reset;
    logic       clr;
    logic       ah_inen;
    logic       acc_oen;
    logic       s_add;
    logic       s_sub;
    logic       s_and;
    logic       s_mul;
    logic       s_div;
    logic [1:0] hs;
    logic [1:0] ls;
  } ctl_t;

  // Strobe pattern for a state; the op only selects the ALU function in EXEC.
  function automatic ctl_t decode(input state_t s, input logic [OPW-1:0] op);
    ctl_t c;
    c = '0;
    c.busy = (s != ST_IDLE);
    unique case (s)
      ST_IDLE:  c.op_ready = 1'b1;
      ST_CLRS: begin
        c.clr      = 1'b1;
        c.ah_reset = 1'b1;
      end
      ST_LOAD: begin
        c.ah_inen = 1'b1;
        c.hs      = MODE_LOAD;
      end
      ST_EXEC: begin
        c.s_add = (op == OP_ADD);
        c.s_sub = (op == OP_SUB);
        c.s_and = (op == OP_AND);
        c.hs    = MODE_LOAD;
      end
      ST_PREP:  c.ah_reset = 1'b1;
      ST_M_ADD: begin
        c.s_mul = 1'b1;
        c.hs    = MODE_LOAD;
      end
      ST_M_SHF: begin
        c.s_mul = 1'b1;
        c.hs    = MODE_SHR;
        c.ls    = MODE_SHR;
      end
      ST_D_SHF: begin
        c.s_div = 1'b1;
        c.hs    = MODE_SHL;
        c.ls    = MODE_SHL;
      end
      ST_D_SUB: begin
        c.s_div = 1'b1;
        c.hs    = MODE_LOAD;
      end
      ST_OUTP:  c.acc_oen = 1'b1;
      ST_DONE:  c.done    = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/acc_seq_if.sv
// Opcode handshake between the instruction decoder (master) and the sequencer (slave).
interface acc_seq_if;
  import acc_seq_pkg::*;

  logic           op_valid;
  logic [OPW-1:0] op_code;
  logic           op_ready;

  modport master (output op_valid, output op_code, input op_ready);
  modport slave  (input op_valid, input op_code, output op_ready);
endinterface

// File: rtl/acc_seq_cnt.sv
// Iteration counter for multiply/divide steps and OUT hold cycles; term flags the
// cycle on which the count equals the caller-supplied last value.
module acc_seq_cnt #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] last,
  output logic          term
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign term = (count == last);

endmodule

// File: rtl/acc_seq.sv
// Control sequencer for the 4-bit accumulator/ALU datapath: accepts one opcode per
// handshake and steps the datapath strobes, including iterative multiply/divide.
module acc_seq
  import acc_seq_pkg::*;
#(
  parameter int unsigned DW      = 4,
  parameter int unsigned CW      = 2,
  parameter int unsigned OUT_CYC = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  acc_seq_if.slave   op,
  output logic       busy,
  output logic       done,
  output logic       ah_reset,
  output logic       clr,
  output logic       ah_inen,
  output logic       acc_oen,
  output logic       s_add,
  output logic       s_sub,
  output logic       s_and,
  output logic       s_mul,
  output logic       s_div,
  output logic [1:0] hs,
  output logic [1:0] ls
);

  state_t         state, state_nx;
  logic [OPW-1:0] op_q, op_nx;
  ctl_t           ctl;
  logic           accept;
  logic           cnt_clr, cnt_en, cnt_term;
  logic [CW-1:0]  cnt_last;

  assign accept = op.op_valid & ctl.op_ready;

  // One counter serves both loops; the terminal value depends on which loop is running.
  assign cnt_clr  = accept | (state == ST_PREP);
  assign cnt_en   = ((state == ST_M_SHF) || (state == ST_D_SUB) || (state == ST_OUTP)) & ~cnt_term;
  assign cnt_last = (state == ST_OUTP) ? CW'(OUT_CYC - 1) : CW'(DW - 1);

  acc_seq_cnt #(.CW(CW)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .last    (cnt_last),
    .term    (cnt_term)
  );

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          op_nx = op.op_code;
          unique case (op.op_code)
            OP_CLR:                 state_nx = ST_CLRS;
            OP_LDA:                 state_nx = ST_LOAD;
            OP_ADD, OP_SUB, OP_AND: state_nx = ST_EXEC;
            OP_MUL, OP_DIV:         state_nx = ST_PREP;
            default:                state_nx = ST_OUTP;
          endcase
        end
      end
      ST_CLRS, ST_LOAD, ST_EXEC: state_nx = ST_DONE;
      ST_PREP:  state_nx = (op_q == OP_DIV) ? ST_D_SHF : ST_M_ADD;
      ST_M_ADD: state_nx = ST_M_SHF;
      ST_M_SHF: state_nx = cnt_term ? ST_DONE : ST_M_ADD;
      ST_D_SHF: state_nx = ST_D_SUB;
      ST_D_SUB: state_nx = cnt_term ? ST_DONE : ST_D_SHF;
      ST_OUTP:  state_nx = cnt_term ? ST_DONE : ST_OUTP;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      ctl          <= '0;
      ctl.op_ready <= 1'b1;
    end else begin
      state <= state_nx;
      op_q  <= op_nx;
      ctl   <= decode(state_nx, op_nx);
    end
  end

  assign op.op_ready = ctl.op_ready;
  assign busy        = ctl.busy;
  assign done        = ctl.done;
  assign ah_reset    = ctl.ah_reset;
  assign clr         = ctl.clr;
  assign ah_inen     = ctl.ah_inen;
  assign acc_oen     = ctl.acc_oen;
  assign s_add       = ctl.s_add;
  assign s_sub       = ctl.s_sub;
  assign s_and       = ctl.s_and;
  assign s_mul       = ctl.s_mul;
  assign s_div       = ctl.s_div;
  assign hs          = ctl.hs;
  assign ls          = ctl.ls;

endmodule

// File: tb/tb_acc_seq.sv
// Scoreboard bench for acc_seq: stimulus queues expected latency/strobe/datapath results,
// a monitor measures each op up to its done pulse, and a small accumulator model follows the strobes.
module tb_acc_seq;
  import acc_seq_pkg::*;

  localparam int unsigned DW      = 4;
  localparam int unsigned CW      = 2;
  localparam int unsigned OUT_CYC = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       busy, done, ah_reset, clr, ah_inen, acc_oen;
  logic       s_add, s_sub, s_and, s_mul, s_div;
  logic [1:0] hs, ls;

  always #5 clk = ~clk;

  acc_seq_if bus ();

  acc_seq #(.DW(DW), .CW(CW), .OUT_CYC(OUT_CYC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (bus),
    .busy     (busy),
    .done     (done),
    .ah_reset (ah_reset),
    .clr      (clr),
    .ah_inen  (ah_inen),
    .acc_oen  (acc_oen),
    .s_add    (s_add),
    .s_sub    (s_sub),
    .s_and    (s_and),
    .s_mul    (s_mul),
    .s_div    (s_div),
    .hs       (hs),
    .ls       (ls)
  );

  // Accumulator datapath model driven only by the sequencer strobes
  logic [3:0] m_ah, m_al, opnd_b, bus_in, pre_ah, pre_al;
  logic       m_cy, pre_en;

  always @(posedge clk) begin
    if (pre_en) begin
      m_ah <= pre_ah;
      m_al <= pre_al;
      m_cy <= 1'b0;
    end else if (clr) begin
      m_ah <= '0;
      m_al <= '0;
      m_cy <= 1'b0;
    end else if (ah_reset) begin
      m_ah <= '0;
      m_cy <= 1'b0;
    end else if (hs == MODE_LOAD) begin
      if (ah_inen) m_ah <= bus_in;
      else if (s_add) m_ah <= m_ah + opnd_b;
      else if (s_sub) m_ah <= m_ah - opnd_b;
      else if (s_and) m_ah <= m_ah & opnd_b;
      else if (s_mul) begin
        if (m_al[0]) {m_cy, m_ah} <= {1'b0, m_ah} + {1'b0, opnd_b};
      end else if (s_div) begin
        if ({m_cy, m_ah} >= {1'b0, opnd_b}) begin
          m_ah    <= m_ah - opnd_b;
          m_al[0] <= 1'b1;
          m_cy    <= 1'b0;
        end
      end
    end else if (hs == MODE_SHR && ls == MODE_SHR) begin
      {m_cy, m_ah, m_al} <= {1'b0, m_cy, m_ah, m_al[3:1]};
    end else if (hs == MODE_SHL && ls == MODE_SHL) begin
      {m_cy, m_ah, m_al} <= {m_ah, m_al, 1'b0};
    end
  end

  typedef struct {
    logic [2:0]  op;
    int unsigned lat;
    int unsigned act;
    logic [8:0]  mask;
    bit          chk;
    logic [3:0]  ah;
    logic [3:0]  al;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] cur_mask();
    return {acc_oen, clr, ah_reset, ah_inen, s_div, s_mul, s_and, s_sub, s_add};
  endfunction

  function automatic exp_t expect_of(input logic [2:0] code, input bit chk,
                                     input logic [3:0] ah, input logic [3:0] al);
    exp_t e;
    e.op = code; e.chk = chk; e.ah = ah; e.al = al;
    e.lat = 2; e.act = 1;
    case (code)
      OP_CLR:  e.mask = 9'h0C0;
      OP_LDA:  e.mask = 9'h020;
      OP_ADD:  e.mask = 9'h001;
      OP_SUB:  e.mask = 9'h002;
      OP_AND:  e.mask = 9'h004;
      OP_MUL:  begin e.mask = 9'h048; e.lat = 2 + 2 * DW; e.act = 2 * DW; end
      OP_DIV:  begin e.mask = 9'h050; e.lat = 2 + 2 * DW; e.act = 2 * DW; end
      default: begin e.mask = 9'h100; e.lat = OUT_CYC + 1; e.act = OUT_CYC; end
    endcase
    return e;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_op_ready"}, 32'(bus.op_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_strobes"}, 32'(cur_mask()), 32'd0);
    check({tag, "_hs_ls"}, 32'({hs, ls}), 32'd0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] code, input bit push, input bit chk,
                       input logic [3:0] ah, input logic [3:0] al);
    int unsigned w = 0;
    while (!bus.op_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.op_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (push) q.push_back(expect_of(code, chk, ah, al));
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned w = 0;
    while ((q.size() != 0 || !bus.op_ready) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (q.size() != 0 || !bus.op_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic preload(input logic [3:0] ah, input logic [3:0] al);
    pre_ah = ah;
    pre_al = al;
    pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic run_monitor();
    bit          in_op = 0;
    bit          post_done = 0;
    int unsigned lat = 0;
    int unsigned act = 0;
    logic [8:0]  mask = '0;
    int unsigned n_s;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_op = 0;
        post_done = 0;
        continue;
      end
      n_s = 32'(s_add) + 32'(s_sub) + 32'(s_and) + 32'(s_mul) + 32'(s_div);
      check("alu_onehot", 32'(n_s <= 1), 32'd1);
      check("oen_excl", 32'(acc_oen && (hs != 2'b00 || ls != 2'b00 || ah_inen || n_s != 0)), 32'd0);
      if (post_done) begin
        check("ready_after_done", 32'(bus.op_ready), 32'd1);
        post_done = 0;
      end
      if (in_op) begin
        lat++;
        if (n_s != 0 || ah_inen || clr || acc_oen) act++;
        mask |= cur_mask();
        if (done) begin
          in_op = 0;
          post_done = 1;
          if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("latency", lat, e.lat);
            check("active_cycles", act, e.act);
            check("strobe_set", 32'(mask), 32'(e.mask));
            if (e.chk) check("acc_result", 32'({m_ah, m_al}), 32'({e.ah, e.al}));
          end
        end
      end else if (done) begin
        check("unexpected_done", 32'd1, 32'd0);
      end
      if (bus.op_valid && bus.op_ready) begin
        in_op = 1;
        lat = 0;
        act = 0;
        mask = '0;
      end
    end
  endtask

  task automatic run_stim();
    reset_n = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code = '0;
    pre_en = 1'b0; pre_ah = '0; pre_al = '0;
    opnd_b = '0; bus_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_CLR, 1, 1, 4'h0, 4'h0); wait_idle();
    bus_in = 4'h3;
    issue(OP_LDA, 1, 1, 4'h3, 4'h0); wait_idle();
    opnd_b = 4'h5;
    issue(OP_ADD, 1, 1, 4'h8, 4'h0); wait_idle();
    opnd_b = 4'h2;
    issue(OP_SUB, 1, 1, 4'h6, 4'h0); wait_idle();
    opnd_b = 4'h4;
    issue(OP_AND, 1, 1, 4'h4, 4'h0); wait_idle();

    preload(4'h0, 4'h7); opnd_b = 4'h3;
    issue(OP_MUL, 1, 1, 4'h1, 4'h5); wait_idle();
    preload(4'h0, 4'hD); opnd_b = 4'h3;
    issue(OP_DIV, 1, 1, 4'h1, 4'h4); wait_idle();

    // op_valid held through OUTP/DONE must not start another op
    issue(OP_OUT, 1, 1, 4'h1, 4'h4);
    bus.op_valid = 1'b1;
    bus.op_code  = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    wait_idle();

    // back-to-back single-step ops
    opnd_b = 4'h1;
    issue(OP_ADD, 1, 1, 4'h2, 4'h4);
    issue(OP_ADD, 1, 1, 4'h3, 4'h4);
    wait_idle();

    // asynchronous reset in the middle of a multiply
    preload(4'h0, 4'h7); opnd_b = 4'h3;
    issue(OP_MUL, 0, 0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_mul_shift", 32'({hs, ls, s_mul}), 32'({MODE_SHR, MODE_SHR, 1'b1}));
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    check_idle_outputs("reset_hold");
    @(posedge clk); #1;
    reset_n = 1'b1;
    opnd_b = 4'h5;
    issue(OP_ADD, 1, 0, 4'h0, 4'h0);
    wait_idle();

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      issue(3'($urandom_range(0, 7)), 1, 0, 4'h0, 4'h0);
    end
    wait_idle();
  endtask

  initial begin
    fork
      run_monitor();
      run_stim();
      begin
        #900000;
        check("global_timeout", 32'd0, 32'd1);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
